afe_cfg_seq: RTL
================

AFE_CFG_SEQ -- requirements
Module: afe_cfg_seq

Interface
REQ-001 Parameter POT_WR_CMD, default 8'h13, SHALL be the command byte for a digital-pot write.
REQ-002 Parameter TIMEOUT, default 1023, SHALL be the max cycles to wait for SPI_done per transaction.
REQ-003 Parameter AUTO_START, default 1, SHALL start one sequence on the first cycle after reset deasserts when 1.
REQ-004 Port clk  in  1  system clock; the block SHALL use this one clock only.
REQ-005 Port rst  in  1  reset, synchronous and active-high.
REQ-006 Port start  in  1  single-cycle request to run the configuration sequence.
REQ-007 Ports ch1_gain, ch2_gain, ch3_gain  in  3 each  requested gain index per channel.
REQ-008 Port trig_lvl  in  8  trigger pot value.
REQ-009 Port wrt_SPI  out  1  single-cycle launch pulse to the SPI master.
REQ-010 Port SPI_cmd  out  16  command word to the SPI master.
REQ-011 Port ss  out  3  slave select code: 000 trig, 001 ch1, 010 ch2, 011 ch3, 100 EEP, 111 none.
REQ-012 Port SPI_done  in  1  SPI master transaction complete.
REQ-013 Port EEP_data  in  8  byte returned by the EEPROM; valid in the SPI_done cycle.
REQ-014 Ports cal_ch1, cal_ch2, cal_ch3  out  8 each  last calibration byte read per channel.
REQ-015 Ports busy, done, err  out  1 each  sequence active; one-cycle completion pulse; sticky timeout flag.

Function
REQ-016 A sequence SHALL consist of 7 SPI transactions in fixed order: EEP rd ch1, pot wr ch1, EEP rd ch2, pot wr ch2, EEP rd ch3, pot wr ch3, pot wr trig.
REQ-017 Each EEP read SHALL use ss=100 and SPI_cmd={2'b00,1'b0,n[1:0],gain[2:0],8'h00}, where n=channel-1 and gain is the latched gain for that channel.
REQ-018 Each pot write SHALL use SPI_cmd={POT_WR_CMD,value}, where value is the byte just read for a channel, or trig_lvl for the trigger.
REQ-019 The FSM SHALL use states IDLE, LAUNCH, WAIT, NEXT, DONE; the step index 0..6 SHALL select ss and SPI_cmd.
REQ-020 IDLE->LAUNCH on start (or auto-start); gains and trig_lvl SHALL be latched on that edge and held for the whole sequence.
REQ-021 In LAUNCH, wrt_SPI SHALL be high exactly one cycle, with ss and SPI_cmd already valid in that cycle; LAUNCH->WAIT.
REQ-022 ss and SPI_cmd SHALL stay stable from LAUNCH through the SPI_done cycle; ss SHALL return to 111 only in IDLE/DONE.
REQ-023 WAIT->NEXT on SPI_done; on a read step, EEP_data SHALL be captured into an internal byte and cal_chN in that same cycle.
REQ-024 NEXT SHALL increment the step and go to LAUNCH; after step 6, NEXT SHALL go to DONE. NEXT SHALL be one idle cycle between transactions.
REQ-025 DONE SHALL pulse done for one cycle and then return to IDLE.
REQ-026 The WAIT timeout counter SHALL clear in LAUNCH; if it reaches TIMEOUT without SPI_done, the FSM SHALL set err, abort to IDLE with ss=111, and SHALL NOT pulse done.
REQ-027 err SHALL clear only on reset or on the next accepted start.
REQ-028 start while busy SHALL be ignored; SPI_done outside WAIT SHALL be ignored.
REQ-029 busy SHALL be high in every state except IDLE.
REQ-030 Latency with an immediate SPI_done (i.e., done the cycle after wrt) SHALL be 7*3+1 = 22 cycles from start to the done pulse.

Reset
REQ-031 On rst, all of the following SHALL take effect on the next clk edge, including mid-sequence: state IDLE, step 0, wrt_SPI 0, ss 111, SPI_cmd 0, cal_ch1..3 0, busy 0, done 0, err 0, timeout counter 0.
REQ-032 An in-flight SPI transaction SHALL be abandoned; SPI_done arriving after reset SHALL be ignored.

Structure
REQ-033 The ss codes, POT_WR_CMD default, the EEP read opcode and the state encoding SHALL live in shared package afe_cfg_pkg.
REQ-034 The timeout counter SHALL be a sub-module spi_watchdog (inputs clr, en; output expired); everything else SHALL be a single FSM.

Verification
REQ-035 Gains 3/5/7, trig_lvl 8'h80, EEP returns 8'hA1/A2/A3, SPI_done 1 cycle after wrt -> cmds 16'h0300,13A1,0D00,13A2,1700,13A3,1380; ss 4,1,4,2,4,3,0; done at cycle 22; cal_ch1..3 = A1/A2/A3.
REQ-036 SPI_done is never returned on step 2 -> err=1 after 1023 wait cycles, ss=111, busy=0, no done pulse; the next start clears err.
REQ-037 rst asserted in WAIT of step 4 -> next cycle IDLE, ss=111, cal regs 0; a late SPI_done causes no change.
REQ-038 start pulsed during step 3, and gains changed mid-sequence -> the sequence is not restarted and the original latched gains are used throughout.
REQ-039 AUTO_START=1 and rst released with no start -> sequence begins; with AUTO_START=0 -> the block stays IDLE until start.
REQ-040 Random SPI_done delay of 1-50 cycles -> ss and SPI_cmd stay stable across each WAIT, and exactly 7 wrt_SPI pulses occur per sequence.

Source files
------------

// File: rtl/afe_cfg_pkg.sv
// Shared definitions for the AFE configuration sequencer: slave-select codes,
// command opcodes and the sequencer state encoding.
package afe_cfg_pkg;

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        LAUNCH = 3'd1,
        WAIT   = 3'd2,
        NEXT   = 3'd3,
        DONE   = 3'd4
    } state_t;

    localparam logic [2:0] SS_TRIG = 3'b000;
    localparam logic [2:0] SS_CH1  = 3'b001;
    localparam logic [2:0] SS_CH2  = 3'b010;
    localparam logic [2:0] SS_CH3  = 3'b011;
    localparam logic [2:0] SS_EEP  = 3'b100;
    localparam logic [2:0] SS_NONE = 3'b111;

    localparam logic [7:0] POT_WR_CMD_DEF = 8'h13;
    localparam logic [2:0] EEP_RD_OP      = 3'b000;

    // EEPROM address is {channel index, gain}; low byte is a dummy for the read-back.
    function automatic logic [15:0] eep_rd_cmd(input logic [1:0] n, input logic [2:0] gain);
        return {EEP_RD_OP, n, gain, 8'h00};
    endfunction

endpackage

// File: rtl/spi_watchdog.sv
// Counts cycles spent waiting on the SPI master; flags expiry after TIMEOUT cycles.
module spi_watchdog #(
    parameter int unsigned TIMEOUT = 1023
) (
    input  logic clk,
    input  logic rst,
    input  logic clr,
    input  logic en,
    output logic expired
);
    localparam int unsigned CW = $clog2(TIMEOUT + 1);

    logic [CW-1:0] cnt_q, cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (clr) begin
            cnt_d = '0;
        end else if (en) begin
            cnt_d = cnt_q + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    // Asserted during the TIMEOUT-th waiting cycle so the abort lands as the count reaches TIMEOUT.
    assign expired = (cnt_q == CW'(TIMEOUT - 1));

endmodule

// File: rtl/afe_cfg_seq.sv
// AFE configuration sequencer: reads a calibration byte per channel from the EEPROM,
// writes it to that channel's digital pot, then writes the trigger-level pot.
module afe_cfg_seq
    import afe_cfg_pkg::*;
#(
    parameter logic [7:0]  POT_WR_CMD = POT_WR_CMD_DEF,
    parameter int unsigned TIMEOUT    = 1023,
    parameter bit          AUTO_START = 1'b1
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        start,
    input  logic [2:0]  ch1_gain,
    input  logic [2:0]  ch2_gain,
    input  logic [2:0]  ch3_gain,
    input  logic [7:0]  trig_lvl,
    output logic        wrt_SPI,
    output logic [15:0] SPI_cmd,
    output logic [2:0]  ss,
    input  logic        SPI_done,
    input  logic [7:0]  EEP_data,
    output logic [7:0]  cal_ch1,
    output logic [7:0]  cal_ch2,
    output logic [7:0]  cal_ch3,
    output logic        busy,
    output logic        done,
    output logic        err
);
    localparam logic [2:0] LAST_STEP = 3'd6;

    state_t     state_q, state_d;
    logic [2:0] step_q, step_d;
    logic [2:0] gain1_q, gain1_d, gain2_q, gain2_d, gain3_q, gain3_d;
    logic [7:0] trig_q, trig_d, rd_byte_q, rd_byte_d;
    logic [7:0] cal1_q, cal1_d, cal2_q, cal2_d, cal3_q, cal3_d;
    logic       err_q, err_d, auto_q, auto_d;
    logic       wd_clr, wd_en, wd_expired;

    spi_watchdog #(.TIMEOUT(TIMEOUT)) u_watchdog (
        .clk     (clk),
        .rst     (rst),
        .clr     (wd_clr),
        .en      (wd_en),
        .expired (wd_expired)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= IDLE;
            step_q    <= '0;
            gain1_q   <= '0;
            gain2_q   <= '0;
            gain3_q   <= '0;
            trig_q    <= '0;
            rd_byte_q <= '0;
            cal1_q    <= '0;
            cal2_q    <= '0;
            cal3_q    <= '0;
            err_q     <= 1'b0;
            auto_q    <= AUTO_START;
        end else begin
            state_q   <= state_d;
            step_q    <= step_d;
            gain1_q   <= gain1_d;
            gain2_q   <= gain2_d;
            gain3_q   <= gain3_d;
            trig_q    <= trig_d;
            rd_byte_q <= rd_byte_d;
            cal1_q    <= cal1_d;
            cal2_q    <= cal2_d;
            cal3_q    <= cal3_d;
            err_q     <= err_d;
            auto_q    <= auto_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        step_d    = step_q;
        gain1_d   = gain1_q;
        gain2_d   = gain2_q;
        gain3_d   = gain3_q;
        trig_d    = trig_q;
        rd_byte_d = rd_byte_q;
        cal1_d    = cal1_q;
        cal2_d    = cal2_q;
        cal3_d    = cal3_q;
        err_d     = err_q;
        auto_d    = auto_q;
        wd_clr    = 1'b0;
        wd_en     = 1'b0;
        case (state_q)
            IDLE: begin
                if (start || auto_q) begin
                    state_d = LAUNCH;
                    step_d  = '0;
                    gain1_d = ch1_gain;
                    gain2_d = ch2_gain;
                    gain3_d = ch3_gain;
                    trig_d  = trig_lvl;
                    err_d   = 1'b0;
                    auto_d  = 1'b0;
                end
            end
            LAUNCH: begin
                wd_clr  = 1'b1;
                state_d = WAIT;
            end
            WAIT: begin
                wd_en = 1'b1;
                if (SPI_done) begin
                    state_d = NEXT;
                    // Even steps below the trigger write are EEPROM reads.
                    if (!step_q[0] && step_q != LAST_STEP) begin
                        rd_byte_d = EEP_data;
                        case (step_q)
                            3'd0:    cal1_d = EEP_data;
                            3'd2:    cal2_d = EEP_data;
                            default: cal3_d = EEP_data;
                        endcase
                    end
                end else if (wd_expired) begin
                    err_d   = 1'b1;
                    state_d = IDLE;
                    step_d  = '0;
                end
            end
            NEXT: begin
                if (step_q == LAST_STEP) begin
                    state_d = DONE;
                end else begin
                    step_d  = step_q + 3'd1;
                    state_d = LAUNCH;
                end
            end
            DONE: begin
                state_d = IDLE;
                step_d  = '0;
            end
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        ss      = SS_NONE;
        SPI_cmd = '0;
        if (state_q == LAUNCH || state_q == WAIT || state_q == NEXT) begin
            case (step_q)
                3'd0: begin ss = SS_EEP;  SPI_cmd = eep_rd_cmd(2'd0, gain1_q); end
                3'd1: begin ss = SS_CH1;  SPI_cmd = {POT_WR_CMD, rd_byte_q};   end
                3'd2: begin ss = SS_EEP;  SPI_cmd = eep_rd_cmd(2'd1, gain2_q); end
                3'd3: begin ss = SS_CH2;  SPI_cmd = {POT_WR_CMD, rd_byte_q};   end
                3'd4: begin ss = SS_EEP;  SPI_cmd = eep_rd_cmd(2'd2, gain3_q); end
                3'd5: begin ss = SS_CH3;  SPI_cmd = {POT_WR_CMD, rd_byte_q};   end
                3'd6: begin ss = SS_TRIG; SPI_cmd = {POT_WR_CMD, trig_q};      end
                default: ;
            endcase
        end
    end

    assign wrt_SPI = (state_q == LAUNCH);
    assign busy    = (state_q != IDLE);
    assign done    = (state_q == DONE);
    assign err     = err_q;
    assign cal_ch1 = cal1_q;
    assign cal_ch2 = cal2_q;
    assign cal_ch3 = cal3_q;

endmodule
